// File: rtl/event_tx_queue.sv
// ---------------------------------------------------------------------------
// event_tx_queue
// Board-to-host transmit path. One-cycle board events are captured into
// pending flags, converted to protocol bytes by a fixed-priority arbiter,
// buffered in a small FIFO and handed one at a time to async_transmitter
// through its TxD_start / TxD_busy handshake.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   user_turn_done      event pulse, byte 8'h01
//   draw                event pulse, byte 8'h03
//   resign              event pulse, byte 8'h02
//   new_game            event pulse, byte {2'b11, black_setting, white_setting};
//                       also flushes everything queued behind it
//   movement_done       event pulse, byte 8'h04
//   reset_done          event pulse, byte 8'h05
//   offset_done         event pulse, byte 8'h06
//   scan_valid/byte     event pulse, scan_byte sent raw
//   black/white_setting sampled with new_game
//   TxD_busy            transmitter busy
//   TxD_start           one-cycle start strobe
//   TxD_data            byte to send, held until the next strobe
//   queue_empty         FIFO empty and nothing pending
//   overflow            sticky: a scan byte was dropped
// ---------------------------------------------------------------------------
module event_tx_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         user_turn_done,
  input  logic         draw,
  input  logic         resign,
  input  logic         new_game,
  input  logic         movement_done,
  input  logic         reset_done,
  input  logic         offset_done,
  input  logic         scan_valid,
  input  logic [7:0]   scan_byte,
  input  logic [2:0]   black_setting,
  input  logic [2:0]   white_setting,
  input  logic         TxD_busy,
  output logic         TxD_start,
  output logic [7:0]   TxD_data,
  output logic         queue_empty,
  output logic         overflow
);

  // Pending-flag index doubles as priority: bit 0 is served first.
  localparam int P_SCAN = 0, P_MOVE = 1, P_RST = 2, P_OFS = 3,
                 P_TURN = 4, P_DRAW = 5, P_RESIGN = 6, P_NEWG = 7;

  typedef enum logic [1:0] {S_IDLE, S_START, S_HOLD, S_WAIT} tx_state_t;

  logic [7:0]    r_pend;
  logic [7:0]    r_scan_hold;
  logic [7:0]    r_ng_code;
  logic          r_overflow;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_tx_data;
  tx_state_t     r_state, w_next;

  logic [7:0]    w_pulse, w_accept, w_lowest, w_grant, w_wr_byte;
  logic          w_full, w_wr, w_pop, w_scan_free;

  assign w_pulse = {new_game, resign, draw, user_turn_done,
                    offset_done, reset_done, movement_done, scan_valid};

  // ---------------- arbiter ----------------
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_wr     = (r_pend != 8'd0) && !w_full;
  assign w_lowest = r_pend & (~r_pend + 8'd1);   // isolate lowest set bit
  assign w_grant  = w_wr ? w_lowest : 8'd0;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_wr_byte = 8'h00;
    case (1'b1)
      w_grant[P_SCAN]:   w_wr_byte = r_scan_hold;
      w_grant[P_MOVE]:   w_wr_byte = 8'h04;
      w_grant[P_RST]:    w_wr_byte = 8'h05;
      w_grant[P_OFS]:    w_wr_byte = 8'h06;
      w_grant[P_TURN]:   w_wr_byte = 8'h01;
      w_grant[P_DRAW]:   w_wr_byte = 8'h03;
      w_grant[P_RESIGN]: w_wr_byte = 8'h02;
      w_grant[P_NEWG]:   w_wr_byte = r_ng_code;
      default:           w_wr_byte = 8'h00;
    endcase
  end

  // ---------------- capture ----------------
  // The scan holding register is free if nothing is held, or if the held byte
  // is moving into the FIFO on this very edge.
  assign w_scan_free = !r_pend[P_SCAN] || w_grant[P_SCAN];

  always_comb begin
    w_accept         = w_pulse;
    w_accept[P_SCAN] = scan_valid && w_scan_free;
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend      <= 8'd0;
      r_scan_hold <= 8'd0;
      r_ng_code   <= 8'd0;
      r_overflow  <= 1'b0;
    end else if (new_game) begin
      // Flush: only the new_game flag survives, overflow history is dropped.
      r_pend      <= 8'd1 << P_NEWG;
      r_ng_code   <= {2'b11, black_setting, white_setting};
      r_scan_hold <= 8'd0;
      r_overflow  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_accept;
      if (w_accept[P_SCAN]) r_scan_hold <= scan_byte;
      if (scan_valid && !w_scan_free) r_overflow <= 1'b1;
    end
  end

  // ---------------- FIFO ----------------
  // NOTE: the storage array has no reset; pointers and count define validity,
  // so clearing the data itself would buy nothing.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_wr_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (new_game) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_pop) r_tx_data <= r_mem[r_rptr];
    end
  end

  // START and HOLD cover the cycle before the transmitter raises busy, so
  // WAIT never sees a stale busy=0 from before the strobe.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:  if (r_count != '0 && !TxD_busy) begin
                 w_pop  = 1'b1;
                 w_next = S_START;
               end
      S_START: w_next = S_HOLD;
      S_HOLD:  w_next = S_WAIT;
      S_WAIT:  if (!TxD_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign TxD_start   = (r_state == S_START);
  assign TxD_data    = r_tx_data;
  assign queue_empty = (r_count == '0) && (r_pend == 8'd0);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_event_tx_queue.sv
module tb_event_tx_queue;

  localparam int BUSY_LEN = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       user_turn_done = 1'b0, draw = 1'b0, resign = 1'b0, new_game = 1'b0;
  logic       movement_done = 1'b0, reset_done = 1'b0, offset_done = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_byte = 8'h00;
  logic [2:0] black_setting = 3'd0, white_setting = 3'd0;
  logic       TxD_busy, TxD_start, queue_empty, overflow;
  logic [7:0] TxD_data;

  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] sent [$];
  int         n_total = 0, n_bad = 0;

  event_tx_queue #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .user_turn_done(user_turn_done), .draw(draw), .resign(resign),
    .new_game(new_game), .movement_done(movement_done),
    .reset_done(reset_done), .offset_done(offset_done),
    .scan_valid(scan_valid), .scan_byte(scan_byte),
    .black_setting(black_setting), .white_setting(white_setting),
    .TxD_busy(TxD_busy), .TxD_start(TxD_start), .TxD_data(TxD_data),
    .queue_empty(queue_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the edge after the strobe, lasts BUSY_LEN.
  assign TxD_busy = hold_busy || (busy_cnt != 0);
  always @(posedge clk) begin
    if (TxD_start)         busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Record every strobed byte, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && TxD_start) sent.push_back(TxD_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [31:0] sent_at(input int i);
    return (i < sent.size()) ? {24'h0, sent[i]} : 32'hFFFF_FFFF;
  endfunction

  // Mask bits: 0 scan,1 move,2 reset_done,3 offset,4 turn,5 draw,6 resign,7 new_game.
  task automatic pulse(input logic [7:0] m, input logic [7:0] sb,
                       input logic [2:0] bs, input logic [2:0] ws);
    scan_valid = m[0]; movement_done = m[1]; reset_done = m[2];
    offset_done = m[3]; user_turn_done = m[4]; draw = m[5];
    resign = m[6]; new_game = m[7];
    scan_byte = sb; black_setting = bs; white_setting = ws;
    @(posedge clk); #1;
    {scan_valid, movement_done, reset_done, offset_done} = 4'b0;
    {user_turn_done, draw, resign, new_game} = 4'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int c = 0;
    while (quiet < 4 && c < 300) begin
      @(posedge clk); #1; c++;
      quiet = (!TxD_busy && queue_empty && !TxD_start) ? quiet + 1 : 0;
    end
    if (quiet < 4) timeout("wait_idle");
  endtask

  task automatic wait_sent(input int n, input int bound, input string name);
    int c = 0;
    while (sent.size() < n && c < bound) begin @(posedge clk); #1; c++; end
    if (sent.size() < n) timeout(name);
  endtask

  typedef struct {
    logic [7:0] mask;
    logic [7:0] sb;
    logic [2:0] bs;
    logic [2:0] ws;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [10];

  logic [7:0] full_mask [9];
  logic [7:0] full_sb   [9];
  logic [7:0] full_exp  [9];

  initial begin
    vecs[0] = '{8'h02, 8'h00, 3'd0, 3'd0, 8'h04};
    vecs[1] = '{8'h04, 8'h00, 3'd0, 3'd0, 8'h05};
    vecs[2] = '{8'h08, 8'h00, 3'd0, 3'd0, 8'h06};
    vecs[3] = '{8'h10, 8'h00, 3'd0, 3'd0, 8'h01};
    vecs[4] = '{8'h20, 8'h00, 3'd0, 3'd0, 8'h03};
    vecs[5] = '{8'h40, 8'h00, 3'd0, 3'd0, 8'h02};
    vecs[6] = '{8'h80, 8'h00, 3'd2, 3'd5, 8'hD5};
    vecs[7] = '{8'h80, 8'h00, 3'd7, 3'd0, 8'hF8};
    vecs[8] = '{8'h01, 8'h5A, 3'd0, 3'd0, 8'h5A};
    vecs[9] = '{8'h01, 8'h00, 3'd0, 3'd0, 8'h00};

    full_mask = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h01, 8'h01, 8'h01};
    full_sb   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h11};
    full_exp  = '{8'h04, 8'h05, 8'h06, 8'h01, 8'h03, 8'h02, 8'h10, 8'h20, 8'h11};

    // ---- reset state ----
    #12;
    check("rst_start", TxD_start, 0);
    check("rst_data", TxD_data, 8'h00);
    check("rst_empty", queue_empty, 1);
    check("rst_ovf", overflow, 0);
    @(posedge clk); #1 reset = 1'b0;
    cycles(2);
    check("rst_empty_after", queue_empty, 1);

    // ---- single events: latency and code ----
    for (int i = 0; i < 10; i++) begin
      int n;
      wait_idle();
      pulse(vecs[i].mask, vecs[i].sb, vecs[i].bs, vecs[i].ws);
      n = 1;
      while (!TxD_start && n < 12) begin @(posedge clk); #1; n++; end
      check($sformatf("vec%0d_latency", i), n, 3);
      check($sformatf("vec%0d_data", i), TxD_data, vecs[i].exp_byte);
    end

    // ---- same-cycle events ----
    wait_idle();
    sent.delete();
    pulse(8'h45, 8'hA5, 3'd0, 3'd0);
    wait_sent(3, 200, "same_cycle_wait");
    cycles(30);
    check("same_cnt", sent.size(), 3);
    check("same_0", sent_at(0), 8'hA5);
    check("same_1", sent_at(1), 8'h05);
    check("same_2", sent_at(2), 8'h02);

    // ---- full FIFO with back-pressure, then scan overflow ----
    wait_idle();
    sent.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pulse(full_mask[i], full_sb[i], 3'd0, 3'd0);
      cycles(1);
    end
    cycles(3);
    check("full_no_strobe", sent.size(), 0);
    check("full_ovf0", overflow, 0);
    check("full_not_empty", queue_empty, 0);
    pulse(8'h01, 8'h22, 3'd0, 3'd0);
    cycles(1);
    check("scan_ovf1", overflow, 1);
    hold_busy = 1'b0;
    wait_sent(9, 600, "full_drain_wait");
    cycles(30);
    check("full_cnt", sent.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("full_%0d", i), sent_at(i), full_exp[i]);
    check("ovf_sticky", overflow, 1);

    // ---- new_game flush with one byte in flight and four queued ----
    wait_idle();
    sent.delete();
    pulse(8'h3E, 8'h00, 3'd0, 3'd0);
    cycles(5);
    pulse(8'h80, 8'h00, 3'd2, 3'd5);
    check("flush_inflight", TxD_data, 8'h04);
    check("flush_ovf0", overflow, 0);
    check("flush_ng_pending", queue_empty, 0);
    wait_sent(2, 200, "flush_wait");
    cycles(40);
    check("flush_cnt", sent.size(), 2);
    check("flush_0", sent_at(0), 8'h04);
    check("flush_1", sent_at(1), 8'hD5);

    // ---- async reset while in WAIT ----
    wait_idle();
    sent.delete();
    pulse(8'h02, 8'h00, 3'd0, 3'd0);
    wait_sent(1, 20, "rstmid_first");
    cycles(3);
    pulse(8'h20, 8'h00, 3'd0, 3'd0);
    cycles(1);
    #3 reset = 1'b1;
    #1;
    check("rstmid_start", TxD_start, 0);
    check("rstmid_empty", queue_empty, 1);
    check("rstmid_data", TxD_data, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    sent.delete();
    pulse(8'h40, 8'h00, 3'd0, 3'd0);
    wait_sent(1, 100, "rstmid_after");
    cycles(40);
    check("rstmid_cnt", sent.size(), 1);
    check("rstmid_byte", sent_at(0), 8'h02);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
